axi_burst_split_write: RTL and testbench

AXI_BURST_SPLIT_WRITE -- requirements
Module: axi_burst_split_write

---
 rtl/axi_split_pkg.sv | 19 +
 rtl/axi_boundary_calc.sv | 40 ++++
 rtl/axi_burst_split_write.sv | 109 ++++++++++
 tb/tb_axi_burst_split_write.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/axi_split_pkg.sv
// Shared state encoding and constant helpers for the AXI write burst splitter.
package axi_split_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_CALC   = 2'd1;
  localparam state_t S_FIRST  = 2'd2;
  localparam state_t S_SECOND = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi_boundary_calc.sv
// Combinational boundary math: aligned start, beats left before the boundary,
// total beats, split decision, first sub-burst size and next-page address.
module axi_boundary_calc
  import axi_split_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BOUNDARY_W = 12,
  parameter int LEN_W      = 8
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic [ADDR_W-1:0]   a_o,
  output logic [BOUNDARY_W:0] b_o,
  output logic [LEN_W:0]      t_o,
  output logic                split_o,
  output logic [LEN_W:0]      f_o,
  output logic [ADDR_W-1:0]   next_addr_o
);

  localparam int OFF_W = clog2(DATA_W / 8);
  localparam int CW    = (BOUNDARY_W > LEN_W) ? BOUNDARY_W + 1 : LEN_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  logic [BOUNDARY_W:0]          span;
  logic [ADDR_W-BOUNDARY_W-1:0] page;

  assign a_o     = addr_i & ALIGN_MASK;
  // Bytes left in the current page, then converted to beats.
  assign span    = {1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, a_o[BOUNDARY_W-1:0]};
  assign b_o     = span >> OFF_W;
  assign t_o     = {1'b0, len_i} + 1'b1;
  assign split_o = CW'(t_o) > CW'(b_o);
  // When split, B < T so B always fits the length-sized field.
  assign f_o     = split_o ? (LEN_W + 1)'(b_o) : t_o;

  assign page        = a_o[ADDR_W-1:BOUNDARY_W] + (ADDR_W - BOUNDARY_W)'(1);
  assign next_addr_o = {page, {BOUNDARY_W{1'b0}}};

endmodule

// File: rtl/axi_burst_split_write.sv
// Splits an upstream write burst that crosses a 2^BOUNDARY_W byte boundary
// into two downstream sub-bursts; data beats pass straight through.
module axi_burst_split_write
  import axi_split_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BOUNDARY_W = 12,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic [LEN_W-1:0]      s_len,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [LEN_W-1:0]      m_len,
  output logic                  m_last,
  output logic                  m_split
);

  state_t              state_q;
  logic [ADDR_W-1:0]   a_q;
  logic [BOUNDARY_W:0] b_q;
  logic [LEN_W:0]      t_q, f_q, cnt_q;
  logic                split_q;

  logic [ADDR_W-1:0]   calc_addr, c_a, c_next;
  logic [BOUNDARY_W:0] c_b;
  logic [LEN_W:0]      c_t, c_f;
  logic                c_split;
  logic                xfer_st, beat;
  logic                unused_b;

  // Live s_addr is sampled in CALC; afterwards the registered start drives the next-page math.
  assign calc_addr = (state_q == S_CALC) ? s_addr : a_q;

  axi_boundary_calc #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOUNDARY_W(BOUNDARY_W), .LEN_W(LEN_W)
  ) u_calc (
    .addr_i(calc_addr), .len_i(s_len), .a_o(c_a), .b_o(c_b), .t_o(c_t),
    .split_o(c_split), .f_o(c_f), .next_addr_o(c_next)
  );

  assign unused_b = ^b_q;
  assign xfer_st  = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign beat     = xfer_st && s_valid && m_ready;

  assign m_valid = xfer_st && s_valid;
  assign s_ready = xfer_st && m_ready;
  assign m_wdata = xfer_st ? s_wdata : '0;
  assign m_wstrb = xfer_st ? s_wstrb : '0;
  assign m_last  = xfer_st && (cnt_q == '0);
  assign m_split = xfer_st && split_q;
  assign m_addr  = (state_q == S_FIRST)  ? a_q :
                   (state_q == S_SECOND) ? c_next : '0;
  assign m_len   = (state_q == S_FIRST)  ? LEN_W'(f_q - 1'b1) :
                   (state_q == S_SECOND) ? LEN_W'(t_q - f_q - 1'b1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      split_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (s_valid) state_q <= S_CALC;
        S_CALC: begin
          a_q     <= c_a;
          b_q     <= c_b;
          t_q     <= c_t;
          f_q     <= c_f;
          split_q <= c_split;
          cnt_q   <= c_f - 1'b1;
          state_q <= S_FIRST;
        end
        S_FIRST: if (beat) begin
          if (cnt_q == '0) begin
            if (split_q) begin
              state_q <= S_SECOND;
              cnt_q   <= t_q - f_q - 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SECOND: if (beat) begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_split_write.sv
// Directed plus randomized bursts against an arithmetic model of page splitting.
module tb_axi_burst_split_write;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [7:0]  s_len = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [7:0]  m_len;
  logic        m_last, m_split;

  int n_vec = 0;
  int n_bad = 0;

  axi_burst_split_write #(.ADDR_W(32), .DATA_W(32), .BOUNDARY_W(12), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_len(s_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len), .m_last(m_last), .m_split(m_split)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_last"},  m_last,  0);
    chk({tag, "_m_split"}, m_split, 0);
    chk({tag, "_m_addr"},  m_addr,  0);
    chk({tag, "_m_len"},   m_len,   0);
  endtask

  // mode 0: full rate, 1: random stalls both sides, 2: m_ready low 3 cycles on beat 2.
  // abort_at >= 0 asserts reset while that beat index is presented.
  task automatic run_burst(input logic [31:0] addr, input int len, input int mode, input int abort_at);
    logic [31:0] a, second, e_addr;
    int          off, b, t, f, k, stall_left, budget, e_len;
    bit          split, sv, mr, first, e_last;
    logic [31:0] data[$];
    logic [3:0]  strb[$];

    a      = addr & 32'hFFFF_FFFC;
    off    = int'(a & 32'h0000_0FFF);
    b      = (4096 - off) / 4;
    t      = len + 1;
    split  = t > b;
    f      = split ? b : t;
    second = ((a >> 12) + 32'd1) << 12;
    for (int i = 0; i < t; i++) begin
      data.push_back($urandom);
      strb.push_back(4'($urandom));
    end

    @(posedge clk); #1;
    s_valid = 1'b1; s_addr = addr; s_len = 8'(len);
    s_wdata = data[0]; s_wstrb = strb[0]; m_ready = 1'b0;
    #1;
    chk("idle_m_valid", m_valid, 0);
    chk("idle_s_ready", s_ready, 0);
    @(posedge clk); #2;
    chk("calc_m_valid", m_valid, 0);
    chk("calc_s_ready", s_ready, 0);

    k = 0; budget = 0;
    stall_left = (mode == 2) ? 3 : 0;
    while (k < t && budget < 4000) begin
      @(posedge clk); #1;
      budget++;
      sv = 1'b1; mr = 1'b1;
      if (mode == 1 && budget > 1) begin
        sv = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 3) != 0);
      end
      if (mode == 2 && k == 1 && stall_left > 0) begin
        mr = 1'b0;
        stall_left--;
      end
      s_valid = sv; m_ready = mr; s_wdata = data[k]; s_wstrb = strb[k];
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk_zero_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        return;
      end
      #1;
      first  = k < f;
      e_addr = first ? a : second;
      e_len  = first ? f - 1 : t - f - 1;
      e_last = first ? (k == f - 1) : (k == t - 1);
      chk("m_valid", m_valid, sv);
      chk("s_ready", s_ready, mr);
      if (sv) begin
        chk("m_addr",  m_addr,  e_addr);
        chk("m_len",   m_len,   e_len);
        chk("m_split", m_split, split);
        chk("m_last",  m_last,  e_last);
        chk("m_wdata", m_wdata, data[k]);
        chk("m_wstrb", m_wstrb, strb[k]);
      end
      if (sv && mr) k++;
    end
    if (k < t) chk("burst_timeout", k, t);

    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("done_m_valid", m_valid, 0);
    chk("done_m_last",  m_last,  0);
  endtask

  initial begin
    logic [31:0] r_addr;
    int          r_len;

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    run_burst(32'h0000_1000, 3,   0, -1);
    run_burst(32'h0000_0FF8, 3,   0, -1);
    run_burst(32'h0000_0F00, 255, 0, -1);
    run_burst(32'h0000_0FF3, 0,   0, -1);
    run_burst(32'h0000_0FF8, 3,   2, -1);
    run_burst(32'h0000_0FF8, 3,   0, 2);
    run_burst(32'h0000_2000, 0,   0, -1);
    run_burst(32'h0000_3000, 255, 1, -1);
    run_burst(32'hFFFF_FFF0, 15,  1, -1);

    for (int n = 0; n < 20; n++) begin
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr[11:8] = 4'hF;
      r_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      run_burst(r_addr, r_len, 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
